// File: rtl/microsequencer_pkg.sv
// Shared control-unit constants: microstate width, well-known microstates and
// the next-state select encodings used by microinstructions and the encoder.
package microsequencer_pkg;

  localparam int CTL_STATE_W = 7;
  localparam logic [CTL_STATE_W-1:0] CTL_FETCH_STATE = 7'd1;
  localparam logic [CTL_STATE_W-1:0] CTL_RESET_STATE = 7'd0;

  typedef enum logic [1:0] {
    NSEL_INC      = 2'b00,
    NSEL_DISPATCH = 2'b01,
    NSEL_BRANCH   = 2'b10,
    NSEL_FETCH    = 2'b11
  } nsel_e;

endpackage

// File: rtl/microsequencer_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags the cycle whose increment
// reaches MEM_TIMEOUT; the counter restarts on that cycle or whenever cleared.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  assign hit       = enable_i && !clear_i && ((cnt_q + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT));
  assign timeout_o = hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || hit) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microstate next-state engine: increment / dispatch / branch / fetch-return
// selection with MFC stalls, a memory-wait watchdog and undefined-opcode trap.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int                   STATE_W     = CTL_STATE_W,
  parameter logic [STATE_W-1:0]   FETCH_STATE = CTL_FETCH_STATE,
  parameter logic [STATE_W-1:0]   RESET_STATE = CTL_RESET_STATE,
  parameter int                   MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] enc_state_in,
  input  logic [1:0]         ctl_nsel,
  input  logic [STATE_W-1:0] ctl_target,
  input  logic               ctl_cond_en,
  input  logic               cond_true,
  input  logic               ctl_mem_wait,
  input  logic               mfc,
  output logic [STATE_W-1:0] state_out,
  output logic               invalid_op,
  output logic               mem_err
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               invalid_q, invalid_d;
  logic               mem_err_q, mem_err_d;
  logic               stall;
  logic               timeout;
  logic               branch_taken;
  logic [STATE_W-1:0] state_inc;

  // MFC in the same cycle as the wait request cancels the stall outright.
  assign stall        = ctl_mem_wait && !mfc;
  assign branch_taken = !ctl_cond_en || cond_true;
  assign state_inc    = state_q + STATE_W'(1);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (!stall),
    .enable_i (stall),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      invalid_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      invalid_q <= invalid_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    invalid_d = 1'b0;
    mem_err_d = 1'b0;
    if (stall) begin
      if (timeout) begin
        state_d   = FETCH_STATE;
        mem_err_d = 1'b1;
      end
    end else begin
      unique case (nsel_e'(ctl_nsel))
        NSEL_INC: state_d = state_inc;
        NSEL_DISPATCH: begin
          if (enc_state_in != '0) begin
            state_d = enc_state_in;
          end else begin
            state_d   = FETCH_STATE;
            invalid_d = 1'b1;
          end
        end
        NSEL_BRANCH: state_d = branch_taken ? ctl_target : state_inc;
        NSEL_FETCH:  state_d = FETCH_STATE;
        default:     state_d = FETCH_STATE;
      endcase
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    state_out  = state_q;
    invalid_op = invalid_q;
    mem_err    = mem_err_q;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Control-unit next-state engine sitting directly downstream of the instruction encoder. Holds the current 7-bit microstate, selects the next microstate each clock from increment, encoder dispatch, conditional branch target or fetch-return, and stalls on memory operations until memory function complete (MFC). A watchdog aborts memory waits that never complete. Undefined opcodes are trapped back to fetch.

## Interface
Parameters:
- STATE_W, 7, microstate width; must match encoder output width.
- FETCH_STATE, 7'd1, first microstate of the instruction-fetch sequence.
- RESET_STATE, 7'd0, microstate loaded on reset.
- MEM_TIMEOUT, 15, maximum consecutive wait cycles before abort; legal range 2..255.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- enc_state_in  in  STATE_W  dispatch target from the instruction encoder; 0 means undecodable.
- ctl_nsel  in  2  next-state select from the current microinstruction: 00 increment, 01 dispatch, 10 branch, 11 fetch-return.
- ctl_target  in  STATE_W  branch target for nsel=10.
- ctl_cond_en  in  1  1 = branch taken only when cond_true; 0 = unconditional.
- cond_true  in  1  condition-tester result for the current instruction.
- ctl_mem_wait  in  1  current microinstruction performs a memory access and must wait for MFC.
- mfc  in  1  memory function complete, level, sampled on clk.
- state_out  out  STATE_W  current microstate (registered).
- invalid_op  out  1  one-cycle pulse: dispatch hit enc_state_in = 0.
- mem_err  out  1  one-cycle pulse: memory wait timed out.

## Operation
- Reset (reset_n low, any time, asynchronous): state_out = RESET_STATE, invalid_op = 0, mem_err = 0, wait counter = 0. Reset mid-wait discards the wait.
- Priority per cycle, evaluated on current state_out and inputs:
  - Wait: ctl_mem_wait=1 and mfc=0 → hold state_out, wait counter +1. If that increment makes counter = MEM_TIMEOUT → next = FETCH_STATE, mem_err pulses, counter cleared.
  - Otherwise counter cleared and ctl_nsel decides:
    - 00: next = state_out + 1, modulo 2^STATE_W (127 wraps to 0).
    - 01: enc_state_in ≠ 0 → next = enc_state_in; enc_state_in = 0 → next = FETCH_STATE, invalid_op pulses.
    - 10: taken when ctl_cond_en=0 or cond_true=1 → next = ctl_target; else next = state_out + 1 (same wrap).
    - 11: next = FETCH_STATE.
- ctl_mem_wait=1 with mfc=1 in the same cycle: no stall; proceeds by ctl_nsel.
- mfc asserted on the timeout cycle itself: mfc wins (no stall that cycle, no mem_err).
- invalid_op and mem_err are never high together; each is high exactly one cycle, aligned with the state_out update it caused.

## Timing
- One state transition per clk; next-state selection combinational, state_out/pulses registered: decision inputs in cycle N → state_out visible in cycle N+1.
- Dispatch latency: enc_state_in sampled on the edge where ctl_nsel=01; target state appears after that edge.
- Wait: with mfc low, state_out held for up to MEM_TIMEOUT−1 edges; on the MEM_TIMEOUT-th waiting edge state_out becomes FETCH_STATE.
- MFC at wait cycle k (k < MEM_TIMEOUT): advance on that edge; total residency in the memory state = k+1 cycles.
- Counter width: ceil(log2(MEM_TIMEOUT+1)), saturation impossible by construction.
- No combinational path from any input to any output.

## Structure
- Shared control package: STATE_W, FETCH_STATE, RESET_STATE, nsel encodings (NSEL_INC, NSEL_DISPATCH, NSEL_BRANCH, NSEL_FETCH). The encoder uses the same STATE_W constant.
- One sub-module: mem_wait_timer (counter, clear/enable inputs, timeout pulse output). Next-state mux and state register stay in microsequencer.

## Test plan
- Reset: hold reset_n low mid-run with state_out = 7'd45 → state_out = 0, pulses 0 immediately (asynchronous); release, nsel=11 → state_out = 1 after one edge.
- Increment/wrap: state 126, nsel=00 for two edges → 127, then 0.
- Dispatch: nsel=01, enc_state_in = 7'd43 → state_out = 43 next edge; enc_state_in = 0 → state_out = 1, invalid_op high exactly one cycle.
- Conditional branch: nsel=10, target 7'd40, cond_en=1: cond_true=0 from state 20 → 21; cond_true=1 → 40; cond_en=0, cond_true=0 → 40.
- MFC wait: state 8, mem_wait=1, mfc low 3 edges then high, nsel=00 → state_out 8,8,8,9; mem_err stays 0.
- Timeout: MEM_TIMEOUT=15, mem_wait=1, mfc held low → 14 held edges, 15th edge state_out = 1 with mem_err pulse; repeat with mfc rising exactly on the 15th edge → advances by nsel, no mem_err.
